// File: rtl/chroni_pkg.sv
// Shared constants and types for the chroni text-mode scanline path.
package chroni_pkg;

  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 8;
  localparam int SCAN_W  = $clog2(GLYPH_H);
  localparam int FONT_AW = 11;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_RUN,
    FS_DRAIN
  } fetch_state_e;

  // Font ROM layout: eight consecutive bytes per glyph, one per scanline.
  function automatic logic [FONT_AW-1:0] font_index(input logic [GLYPH_W-1:0] code,
                                                    input logic [SCAN_W-1:0]  scan);
    return {code, scan};
  endfunction

endpackage

// File: rtl/chroni_line_buf.sv
// Ping-pong glyph line buffer: simple dual-port RAM, bank select is the address MSB.
module chroni_line_buf
  import chroni_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic               vga_clk,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [GLYPH_W-1:0] wr_data,
  input  logic               rd_en,
  input  logic [AW-1:0]      rd_addr,
  output logic [GLYPH_W-1:0] rd_data
);

  logic [GLYPH_W-1:0] mem_q [2**AW];
  logic [GLYPH_W-1:0] rd_data_q;

  // No reset here so the array maps onto block RAM; the read register holds when rd_en is low.
  always_ff @(posedge vga_clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/chroni_text_fetch.sv
// Character-mode scanline prefetcher: text -> font lookup -> back buffer,
// while the front buffer is serialized MSB first at one pixel per clock.
module chroni_text_fetch
  import chroni_pkg::*;
#(
  parameter int COLS    = 80,
  parameter int TEXT_AW = 12
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  input  logic               fetch_start,
  input  logic [TEXT_AW-1:0] fetch_addr,
  input  logic [SCAN_W-1:0]  fetch_scan,
  output logic               fetch_busy,
  output logic [TEXT_AW-1:0] text_addr,
  input  logic [GLYPH_W-1:0] text_data,
  output logic [FONT_AW-1:0] font_addr,
  input  logic [GLYPH_W-1:0] font_data,
  input  logic               swap,
  input  logic               pix_start,
  output logic               pix_out,
  output logic               pix_valid,
  output logic               overrun
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  // cyc_q holds the number of the fetch cycle currently in progress (1 = first address out).
  localparam logic [8:0]    CYC_LAST_ISSUE = 9'(COLS);
  localparam logic [8:0]    CYC_FONT_FIRST = 9'd2;
  localparam logic [8:0]    CYC_FONT_LAST  = 9'(COLS + 1);
  localparam logic [8:0]    CYC_WR_FIRST   = 9'd4;
  localparam logic [8:0]    CYC_WR_LAST    = 9'(COLS + 3);
  localparam logic [8:0]    CYC_END        = 9'(COLS + 4);
  localparam logic [CW-1:0] COL_LAST       = CW'(COLS - 1);

  fetch_state_e        state_q, state_d;
  logic [8:0]          cyc_q, cyc_d;
  logic                busy_q, busy_d;
  logic [TEXT_AW-1:0]  text_addr_q, text_addr_d;
  logic [FONT_AW-1:0]  font_addr_q, font_addr_d;
  logic [SCAN_W-1:0]   scan_q, scan_d;

  logic                front_q, front_d;
  logic                overrun_q, overrun_d;
  logic                valid_q, valid_d;
  logic [CW-1:0]       col_q, col_d;
  logic [2:0]          bit_q, bit_d;

  logic                swap_ok;
  logic                wr_en;
  logic [CW-1:0]       wr_col;
  logic                rd_en;
  logic [CW-1:0]       rd_col;
  logic [GLYPH_W-1:0]  rd_data;

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    busy_d      = busy_q;
    text_addr_d = text_addr_q;
    font_addr_d = font_addr_q;
    scan_d      = scan_q;
    case (state_q)
      FS_IDLE: begin
        if (fetch_start) begin
          state_d     = FS_RUN;
          cyc_d       = 9'd1;
          busy_d      = 1'b1;
          text_addr_d = fetch_addr;
          scan_d      = fetch_scan;
        end
      end
      FS_RUN: begin
        cyc_d = cyc_q + 9'd1;
        if (cyc_q < CYC_LAST_ISSUE) begin
          text_addr_d = text_addr_q + TEXT_AW'(1);
        end
        if (cyc_q == CYC_LAST_ISSUE) begin
          state_d = FS_DRAIN;
        end
      end
      FS_DRAIN: begin
        cyc_d = cyc_q + 9'd1;
        if (cyc_q == CYC_END) begin
          state_d = FS_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = FS_IDLE;
    endcase
    if (state_q != FS_IDLE && cyc_q >= CYC_FONT_FIRST && cyc_q <= CYC_FONT_LAST) begin
      font_addr_d = font_index(text_data, scan_q);
    end
  end

  // The glyph byte for column i arrives in cycle 4+i and is written at the end of that cycle.
  assign wr_en  = (state_q != FS_IDLE) && (cyc_q >= CYC_WR_FIRST) && (cyc_q <= CYC_WR_LAST);
  assign wr_col = CW'(cyc_q - CYC_WR_FIRST);

  always_comb begin
    swap_ok   = swap && !busy_q && !valid_q;
    front_d   = front_q ^ swap_ok;
    overrun_d = overrun_q | (swap && !swap_ok);
    valid_d   = valid_q;
    col_d     = col_q;
    bit_d     = bit_q;
    rd_en     = 1'b0;
    rd_col    = col_q + CW'(1);
    if (pix_start) begin
      valid_d = 1'b1;
      col_d   = '0;
      bit_d   = 3'd7;
      rd_en   = 1'b1;
      rd_col  = '0;
    end else if (valid_q) begin
      if (bit_q != 3'd0) begin
        bit_d = bit_q - 3'd1;
      end else begin
        bit_d = 3'd7;
        if (col_q == COL_LAST) begin
          valid_d = 1'b0;
        end else begin
          col_d = col_q + CW'(1);
          rd_en = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= FS_IDLE;
      cyc_q       <= '0;
      busy_q      <= 1'b0;
      text_addr_q <= '0;
      font_addr_q <= '0;
      scan_q      <= '0;
      front_q     <= 1'b0;
      overrun_q   <= 1'b0;
      valid_q     <= 1'b0;
      col_q       <= '0;
      bit_q       <= 3'd7;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      busy_q      <= busy_d;
      text_addr_q <= text_addr_d;
      font_addr_q <= font_addr_d;
      scan_q      <= scan_d;
      front_q     <= front_d;
      overrun_q   <= overrun_d;
      valid_q     <= valid_d;
      col_q       <= col_d;
      bit_q       <= bit_d;
    end
  end

  // front_d on the read side lets a same-cycle legal swap steer the first read to the new front.
  chroni_line_buf #(
    .AW(CW + 1)
  ) u_line_buf (
    .vga_clk (vga_clk),
    .wr_en   (wr_en),
    .wr_addr ({~front_q, wr_col}),
    .wr_data (font_data),
    .rd_en   (rd_en),
    .rd_addr ({front_d, rd_col}),
    .rd_data (rd_data)
  );

  assign fetch_busy = busy_q;
  assign text_addr  = text_addr_q;
  assign font_addr  = font_addr_q;
  assign overrun    = overrun_q;
  assign pix_valid  = valid_q;
  assign pix_out    = valid_q & rd_data[bit_q];

endmodule

// File: tb/tb_chroni_text_fetch.sv
// Bench for chroni_text_fetch (COLS=4): table-driven fetch vectors plus a pixel scoreboard.
module tb_chroni_text_fetch;

  localparam int COLS    = 4;
  localparam int TEXT_AW = 12;

  logic               vga_clk     = 1'b0;
  logic               reset_n     = 1'b1;
  logic               fetch_start = 1'b0;
  logic [TEXT_AW-1:0] fetch_addr  = '0;
  logic [2:0]         fetch_scan  = '0;
  logic               fetch_busy;
  logic [TEXT_AW-1:0] text_addr;
  logic [7:0]         text_data;
  logic [10:0]        font_addr;
  logic [7:0]         font_data;
  logic               swap        = 1'b0;
  logic               pix_start   = 1'b0;
  logic               pix_out;
  logic               pix_valid;
  logic               overrun;

  int n_checks = 0;
  int n_errors = 0;

  always #5 vga_clk = ~vga_clk;

  chroni_text_fetch #(
    .COLS(COLS),
    .TEXT_AW(TEXT_AW)
  ) dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .fetch_start (fetch_start),
    .fetch_addr  (fetch_addr),
    .fetch_scan  (fetch_scan),
    .fetch_busy  (fetch_busy),
    .text_addr   (text_addr),
    .text_data   (text_data),
    .font_addr   (font_addr),
    .font_data   (font_data),
    .swap        (swap),
    .pix_start   (pix_start),
    .pix_out     (pix_out),
    .pix_valid   (pix_valid),
    .overrun     (overrun)
  );

  // Text RAM and font ROM models with one-cycle registered read.
  logic [7:0] text_mem [4096];
  logic [7:0] font_mem [2048];

  always @(posedge vga_clk) begin
    text_data <= text_mem[text_addr];
    font_data <= font_mem[font_addr];
  end

  // Multi-element fields are packed with column 0 in the top slot, so column i is element COLS-1-i.
  typedef struct packed {
    logic [11:0]       addr;
    logic [2:0]        scan;
    int                swap_cyc;
    int                poke_cyc;
    logic              exp_ovr;
    logic [3:0][7:0]   codes;
    logic [3:0][11:0]  exp_text;
    logic [3:0][10:0]  exp_font;
  } fvec_t;

  fvec_t      vecs [5];
  logic [7:0] mbuf [2][COLS];
  int         mfront = 0;
  logic       exp_q [$];

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_vec(input int idx, input logic [11:0] a, input logic [2:0] s,
                         input int sw, input int pk, input logic ov,
                         input logic [31:0] c, input logic [47:0] t, input logic [43:0] f);
    vecs[idx].addr     = a;
    vecs[idx].scan     = s;
    vecs[idx].swap_cyc = sw;
    vecs[idx].poke_cyc = pk;
    vecs[idx].exp_ovr  = ov;
    vecs[idx].codes    = c;
    vecs[idx].exp_text = t;
    vecs[idx].exp_font = f;
  endtask

  // Pixel scoreboard: one expected bit popped per active pixel, idle pixels must be 0.
  always @(negedge vga_clk) begin
    if (reset_n) begin
      if (pix_valid) begin
        if (exp_q.size() == 0) begin
          check("pix_valid_extra", 32'(pix_valid), 32'd0);
        end else begin
          check("pix_out", 32'(pix_out), 32'(exp_q.pop_front()));
        end
      end else begin
        check("pix_out_idle", 32'(pix_out), 32'd0);
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_busy", 32'(fetch_busy), 32'd0);
    check("rst_text_addr", 32'(text_addr), 32'd0);
    check("rst_font_addr", 32'(font_addr), 32'd0);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_pix_out", 32'(pix_out), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    fetch_start = 1'b0;
    swap        = 1'b0;
    pix_start   = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    mfront  = 0;
    exp_q.delete();
    $display("reset applied at %0t", $time);
  endtask

  task automatic load_text(input int v);
    logic [11:0] ta;
    for (int i = 0; i < COLS; i++) begin
      ta = vecs[v].addr + 12'(i);
      text_mem[ta] = vecs[v].codes[COLS-1-i];
    end
  endtask

  task automatic run_fetch(input int v);
    load_text(v);
    fetch_addr  = vecs[v].addr;
    fetch_scan  = vecs[v].scan;
    fetch_start = 1'b1;
    swap        = (vecs[v].swap_cyc == 0);
    tick();
    for (int c = 1; c <= COLS + 5; c++) begin
      check("fetch_busy", 32'(fetch_busy), 32'(c <= COLS + 4));
      if (c <= COLS)
        check("text_addr", 32'(text_addr), 32'(vecs[v].exp_text[COLS-c]));
      if (c >= 3 && c <= COLS + 2)
        check("font_addr", 32'(font_addr), 32'(vecs[v].exp_font[COLS+2-c]));
      if (c == COLS + 5) begin
        check("text_addr_hold", 32'(text_addr), 32'(vecs[v].exp_text[0]));
        check("font_addr_hold", 32'(font_addr), 32'(vecs[v].exp_font[0]));
      end
      fetch_start = (c == vecs[v].poke_cyc);
      if (c == vecs[v].poke_cyc) fetch_addr = 12'h555;
      swap = (c == vecs[v].swap_cyc);
      tick();
    end
    fetch_start = 1'b0;
    swap        = 1'b0;
    check("overrun_after_fetch", 32'(overrun), 32'(vecs[v].exp_ovr));
    if (vecs[v].swap_cyc == 0) mfront ^= 1;
    for (int i = 0; i < COLS; i++)
      mbuf[mfront ^ 1][i] = font_mem[vecs[v].exp_font[COLS-1-i]];
    $display("fetch vec %0d addr=0x%0h scan=%0d done", v, vecs[v].addr, vecs[v].scan);
  endtask

  task automatic do_swap();
    swap = 1'b1;
    tick();
    swap = 1'b0;
    mfront ^= 1;
    check("overrun_legal_swap", 32'(overrun), 32'(0));
  endtask

  task automatic start_pix(input logic with_swap);
    pix_start = 1'b1;
    swap      = with_swap;
    tick();
    pix_start = 1'b0;
    swap      = 1'b0;
    if (with_swap) mfront ^= 1;
    exp_q.delete();
    for (int c = 0; c < COLS; c++)
      for (int b = 7; b >= 0; b--)
        exp_q.push_back(mbuf[mfront][c][b]);
    $display("line start front=%0d bytes=%h %h %h %h", mfront,
             mbuf[mfront][0], mbuf[mfront][1], mbuf[mfront][2], mbuf[mfront][3]);
  endtask

  task automatic wait_line_done();
    for (int n = 0; n < 200 && exp_q.size() > 0; n++) tick();
    check("line_pixels_left", 32'(exp_q.size()), 32'd0);
    check("pix_valid_after_line", 32'(pix_valid), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int j = 0; j < 4096; j++) text_mem[j] = 8'(j);
    for (int j = 0; j < 2048; j++) font_mem[j] = 8'((j * 73 + 29) ^ (j >> 3));
    font_mem[11'h20B] = 8'h18;

    set_vec(0, 12'h100, 3'd3, -1, 3, 1'b0, 32'h414200FF,
            {12'h100, 12'h101, 12'h102, 12'h103}, {11'h20B, 11'h213, 11'h003, 11'h7FB});
    set_vec(1, 12'hFFE, 3'd5, 2, -1, 1'b1, 32'h107F8001,
            {12'hFFE, 12'hFFF, 12'h000, 12'h001}, {11'h085, 11'h3FD, 11'h405, 11'h00D});
    set_vec(2, 12'h200, 3'd0, 0, -1, 1'b0, 32'h20212223,
            {12'h200, 12'h201, 12'h202, 12'h203}, {11'h100, 11'h108, 11'h110, 11'h118});
    set_vec(3, 12'h300, 3'd7, -1, -1, 1'b1, 32'h01020304,
            {12'h300, 12'h301, 12'h302, 12'h303}, {11'h00F, 11'h017, 11'h01F, 11'h027});
    set_vec(4, 12'h100, 3'd3, -1, -1, 1'b0, 32'h414200FF,
            {12'h100, 12'h101, 12'h102, 12'h103}, {11'h20B, 11'h213, 11'h003, 11'h7FB});

    #3;
    do_reset();

    // Basic fetch (with an ignored restart request), swap, then display.
    run_fetch(0);
    do_swap();
    start_pix(1'b0);
    wait_line_done();

    // Swap during a fetch is refused; the old front is still displayed.
    run_fetch(1);
    start_pix(1'b0);
    wait_line_done();
    do_reset();

    // Swap together with fetch_start, then swap together with pix_start.
    run_fetch(2);
    start_pix(1'b1);
    for (int k = 1; k <= 9; k++) begin
      swap = (k == 4);
      tick();
    end
    swap = 1'b0;
    check("overrun_on_display", 32'(overrun), 32'd1);
    start_pix(1'b0);
    wait_line_done();

    // Fetch the next row while the current one is on screen.
    start_pix(1'b0);
    run_fetch(3);
    wait_line_done();
    swap = 1'b1;
    tick();
    swap = 1'b0;
    mfront ^= 1;
    start_pix(1'b0);
    wait_line_done();

    // Reset in the middle of a fetch, then a clean fetch and display.
    load_text(4);
    fetch_addr  = vecs[4].addr;
    fetch_scan  = vecs[4].scan;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    tick();
    tick();
    do_reset();
    run_fetch(4);
    do_swap();
    start_pix(1'b0);
    wait_line_done();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
